instruction_loader: RTL and testbench

Sequential instruction-word writer for the RISC CPU: it accepts instruction fields over a valid/ready stream and packs them into the 32-bit IR format that the instruction decoder consumes. It rejects unsupported opcodes and writes legal words into consecutive instruction-memory locations. It sits between the bench or boot source and the instruction memory's write port, and fills program memory before the CPU is released.

---
 rtl/instruction_loader.sv | 111 +++++++++++
 tb/tb_instruction_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// Instruction loader: packs streamed field tuples into 32-bit IR words
// and writes legal ones into consecutive instruction-memory locations.
module instruction_loader #(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_da,
    input  logic [4:0]        in_aa,
    input  logic [14:0]       in_low,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] TOP  = '1;

    state_t state;
    logic   last_q;

    function automatic logic legal_op(input logic [6:0] op);
        case (op)
            7'b0000000, 7'b0000010, 7'b0000101, 7'b1100101,
            7'b0001000, 7'b0001010, 7'b0001100, 7'b0000001,
            7'b0100001, 7'b0100010, 7'b0100101, 7'b0101110,
            7'b0101000, 7'b0101010, 7'b0101100, 7'b1100010,
            7'b1000000, 7'b0110000, 7'b0110001, 7'b1100001,
            7'b0100000, 7'b1100000, 7'b1000100, 7'b0000111:
                legal_op = 1'b1;
            default:
                legal_op = 1'b0;
        endcase
    endfunction

    assign in_ready = (state == S_ACCEPT);
    assign busy     = (state == S_ACCEPT) || (state == S_WRITE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            imem_we    <= 1'b0;
            imem_addr  <= BASE;
            imem_wdata <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            count      <= '0;
            last_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        imem_addr <= BASE;
                        count     <= '0;
                        err       <= 1'b0;
                        done      <= 1'b0;
                        state     <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (in_valid) begin
                        if (legal_op(in_opcode)) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= {in_opcode, in_da, in_aa, in_low};
                            last_q     <= in_last;
                            state      <= S_WRITE;
                        end else begin
                            err   <= 1'b1;
                            state <= S_ERROR;
                        end
                    end
                end
                S_WRITE: begin
                    imem_we   <= 1'b0;
                    imem_addr <= imem_addr + ADDR_W'(1);
                    count     <= count + (ADDR_W + 1)'(1);
                    if (last_q) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (imem_addr == TOP) begin
                        // memory full: stop rather than wrap
                        err   <= 1'b1;
                        state <= S_ERROR;
                    end else begin
                        state <= S_ACCEPT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: a default-size instance plus two
// 4-word instances for the full-memory and top-base-address cases.
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1, start2;
    logic        in_valid;
    logic [6:0]  op;
    logic [4:0]  da, aa;
    logic [14:0] lo;
    logic        last;

    logic        r0, we0, busy0, done0, err0;
    logic [7:0]  addr0;
    logic [31:0] wd0;
    logic [8:0]  cnt0;

    logic        r1, we1, busy1, done1, err1;
    logic [1:0]  addr1;
    logic [31:0] wd1;
    logic [2:0]  cnt1;

    logic        r2, we2, busy2, done2, err2;
    logic [1:0]  addr2;
    logic [31:0] wd2;
    logic [2:0]  cnt2;

    int total = 0;
    int bad   = 0;
    int waited;

    always #5 clk = ~clk;

    instruction_loader #(.ADDR_W(8), .BASE_ADDR(0)) u0 (
        .clk(clk), .rst(rst), .start(start0), .in_valid(in_valid),
        .in_ready(r0), .in_opcode(op), .in_da(da), .in_aa(aa),
        .in_low(lo), .in_last(last), .imem_we(we0), .imem_addr(addr0),
        .imem_wdata(wd0), .busy(busy0), .done(done0), .err(err0),
        .count(cnt0)
    );

    instruction_loader #(.ADDR_W(2), .BASE_ADDR(0)) u1 (
        .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid),
        .in_ready(r1), .in_opcode(op), .in_da(da), .in_aa(aa),
        .in_low(lo), .in_last(last), .imem_we(we1), .imem_addr(addr1),
        .imem_wdata(wd1), .busy(busy1), .done(done1), .err(err1),
        .count(cnt1)
    );

    instruction_loader #(.ADDR_W(2), .BASE_ADDR(3)) u2 (
        .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid),
        .in_ready(r2), .in_opcode(op), .in_da(da), .in_aa(aa),
        .in_low(lo), .in_last(last), .imem_we(we2), .imem_addr(addr2),
        .imem_wdata(wd2), .busy(busy2), .done(done2), .err(err2),
        .count(cnt2)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy_of(input int s);
        return (s == 0) ? r0 : ((s == 1) ? r1 : r2);
    endfunction

    // Present a tuple and hold it until handshake or a 20-cycle limit.
    task automatic put(input int s, input logic [6:0] o,
                       input logic [4:0] d, input logic [4:0] a,
                       input logic [14:0] l, input logic lst,
                       input logic exp_acc, output int n);
        logic acc;
        op = o; da = d; aa = a; lo = l; last = lst;
        in_valid = 1'b1;
        n = 0;
        while (!rdy_of(s) && n < 20) begin
            @(negedge clk);
            n++;
        end
        acc = rdy_of(s);
        if (acc) @(negedge clk);
        chk("accept", 64'(acc), 64'(exp_acc));
    endtask

    task automatic pulse(input int s);
        if (s == 0) start0 = 1'b1;
        else if (s == 1) start1 = 1'b1;
        else start2 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        in_valid = 1'b0;
        op = '0; da = '0; aa = '0; lo = '0; last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(r0), 64'd0);
        chk("rst_we", 64'(we0), 64'd0);
        chk("rst_addr", 64'(addr0), 64'd0);
        chk("rst_wdata", 64'(wd0), 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_done", 64'(done0), 64'd0);
        chk("rst_err", 64'(err0), 64'd0);
        chk("rst_count", 64'(cnt0), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic load, valid held between tuples (backpressure)
        pulse(0);
        chk("start_ready", 64'(r0), 64'd1);
        chk("start_busy", 64'(busy0), 64'd1);
        put(0, 7'b0000010, 5'd1, 5'd2, 15'h0C00, 1'b0, 1'b1, waited);
        chk("b0_we", 64'(we0), 64'd1);
        chk("b0_addr", 64'(addr0), 64'd0);
        chk("b0_wdata", 64'(wd0), 64'h04110C00);
        chk("b0_ready_low", 64'(r0), 64'd0);
        put(0, 7'b0100010, 5'd3, 5'd4, 15'h0005, 1'b0, 1'b1, waited);
        chk("bp_gap", 64'(waited), 64'd1);
        chk("b1_we", 64'(we0), 64'd1);
        chk("b1_addr", 64'(addr0), 64'd1);
        chk("b1_wdata", 64'(wd0), 64'h44320005);
        put(0, 7'b1000000, 5'd0, 5'd0, 15'h7FFF, 1'b1, 1'b1, waited);
        chk("bp_gap2", 64'(waited), 64'd1);
        chk("b2_addr", 64'(addr0), 64'd2);
        chk("b2_wdata", 64'(wd0), 64'h80007FFF);
        in_valid = 1'b0;
        @(negedge clk);
        chk("b_we_pulse", 64'(we0), 64'd0);
        chk("b_done", 64'(done0), 64'd1);
        chk("b_count", 64'(cnt0), 64'd3);
        chk("b_err", 64'(err0), 64'd0);
        chk("b_busy", 64'(busy0), 64'd0);

        // Illegal opcode on second tuple
        pulse(0);
        chk("i_done_clr", 64'(done0), 64'd0);
        chk("i_count_clr", 64'(cnt0), 64'd0);
        put(0, 7'b0000010, 5'd0, 5'd0, 15'h0000, 1'b0, 1'b1, waited);
        chk("i0_addr", 64'(addr0), 64'd0);
        chk("i0_wdata", 64'(wd0), 64'h04000000);
        put(0, 7'b1111111, 5'd1, 5'd1, 15'h0001, 1'b0, 1'b1, waited);
        in_valid = 1'b0;
        chk("i_we", 64'(we0), 64'd0);
        chk("i_err", 64'(err0), 64'd1);
        chk("i_count", 64'(cnt0), 64'd1);
        chk("i_done", 64'(done0), 64'd0);
        pulse(0);
        chk("i_err_clr", 64'(err0), 64'd0);
        chk("i_restart", 64'(r0), 64'd1);

        // Start ignored while in ACCEPT
        put(0, 7'b0101110, 5'd31, 5'd0, 15'h1234, 1'b0, 1'b1, waited);
        chk("g0_addr", 64'(addr0), 64'd0);
        chk("g0_wdata", 64'(wd0), 64'h5DF01234);
        in_valid = 1'b0;
        @(negedge clk);
        pulse(0);
        chk("g_ready", 64'(r0), 64'd1);
        chk("g_addr", 64'(addr0), 64'd1);
        chk("g_count", 64'(cnt0), 64'd1);
        put(0, 7'b0000111, 5'd0, 5'd31, 15'h0000, 1'b1, 1'b1, waited);
        chk("g1_addr", 64'(addr0), 64'd1);
        chk("g1_wdata", 64'(wd0), 64'h0E0F8000);
        in_valid = 1'b0;
        @(negedge clk);
        chk("g_done", 64'(done0), 64'd1);
        chk("g_count2", 64'(cnt0), 64'd2);

        // Reset while imem_we is high
        pulse(0);
        put(0, 7'b1100101, 5'd2, 5'd2, 15'h0002, 1'b0, 1'b1, waited);
        chk("r_we_pre", 64'(we0), 64'd1);
        rst = 1'b1;
        #1;
        chk("r_we", 64'(we0), 64'd0);
        chk("r_addr", 64'(addr0), 64'd0);
        chk("r_wdata", 64'(wd0), 64'd0);
        chk("r_count", 64'(cnt0), 64'd0);
        chk("r_ready", 64'(r0), 64'd0);
        chk("r_busy", 64'(busy0), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("r_idle_ready", 64'(r0), 64'd0);
        pulse(0);
        put(0, 7'b0001000, 5'd1, 5'd1, 15'h0001, 1'b1, 1'b1, waited);
        chk("r2_addr", 64'(addr0), 64'd0);
        chk("r2_wdata", 64'(wd0), 64'h10108001);
        in_valid = 1'b0;
        @(negedge clk);
        chk("r2_done", 64'(done0), 64'd1);

        // Full memory on the 4-word instance
        pulse(1);
        for (int i = 0; i < 4; i++) begin
            put(1, 7'b0110001, 5'(i), 5'd0, 15'(i), 1'b0, 1'b1, waited);
            chk("f_we", 64'(we1), 64'd1);
            chk("f_addr", 64'(addr1), 64'(i));
            chk("f_wdata", 64'(wd1), 64'h62000000 | 64'(i << 20) | 64'(i));
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("f_err", 64'(err1), 64'd1);
        chk("f_count", 64'(cnt1), 64'd4);
        chk("f_done", 64'(done1), 64'd0);
        chk("f_busy", 64'(busy1), 64'd0);
        put(1, 7'b0110001, 5'd4, 5'd0, 15'd4, 1'b1, 1'b0, waited);
        chk("f_no_we", 64'(we1), 64'd0);
        chk("f_count_hold", 64'(cnt1), 64'd4);
        in_valid = 1'b0;
        @(negedge clk);

        // Base at top address: one word only
        pulse(2);
        put(2, 7'b1000100, 5'd0, 5'd0, 15'h0000, 1'b0, 1'b1, waited);
        chk("t_we", 64'(we2), 64'd1);
        chk("t_addr", 64'(addr2), 64'd3);
        chk("t_wdata", 64'(wd2), 64'h88000000);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t_err", 64'(err2), 64'd1);
        chk("t_count", 64'(cnt2), 64'd1);
        chk("t_done", 64'(done2), 64'd0);
        pulse(2);
        put(2, 7'b1000100, 5'd0, 5'd0, 15'h0001, 1'b1, 1'b1, waited);
        chk("t2_addr", 64'(addr2), 64'd3);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_done", 64'(done2), 64'd1);
        chk("t2_err", 64'(err2), 64'd0);
        chk("t2_count", 64'(cnt2), 64'd1);
        chk("t2_busy", 64'(busy2), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
